// File: rtl/up_down_sweep_ctrl_pkg.sv
// Shared definitions for the triangle-sweep sequencer: state encoding and default datapath width.
package up_down_sweep_ctrl_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        UP       = 3'd1,
        DWELL_HI = 3'd2,
        DOWN     = 3'd3,
        DWELL_LO = 3'd4,
        DONE     = 3'd5
    } sweep_state_t;

endpackage

// File: rtl/up_down_counter_core.sv
// Loadable up/down counter; load wins over enable, M=1 counts up.
// One-cycle update latency, no backpressure.
module up_down_counter_core
    import up_down_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             M,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (en)
            q <= M ? q + WIDTH'(1) : q - WIDTH'(1);
    end

endmodule

// File: rtl/up_down_sweep_ctrl.sv
// Triangle sweep sequencer lo->hi->lo with end dwell and repeat count; drives the counter core.
// Host handshake is start/busy/done; start is only sampled in IDLE, abort returns to IDLE in one edge.
module up_down_sweep_ctrl
    import up_down_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DWELL_W = 4,
    parameter int REPS_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [REPS_W-1:0]  reps,
    output logic [WIDTH-1:0]   q,
    output logic               M,
    output logic               busy,
    output logic               done,
    output logic               err
);

    sweep_state_t       state, state_nxt;
    logic [WIDTH-1:0]   lo_r, lo_nxt, hi_r, hi_nxt;
    logic [DWELL_W-1:0] dwell_r, dwell_nxt, dcnt, dcnt_nxt;
    logic [REPS_W-1:0]  reps_r, reps_nxt, rep_cnt, rep_cnt_nxt;
    logic               m_r, m_nxt, err_r, err_nxt;
    logic               ctr_en, ctr_load;

    up_down_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (ctr_en),
        .M        (m_r),
        .load     (ctr_load),
        .load_val (lo_nxt),
        .q        (q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lo_r    <= '0;
            hi_r    <= '0;
            dwell_r <= '0;
            dcnt    <= '0;
            reps_r  <= '0;
            rep_cnt <= '0;
            m_r     <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            lo_r    <= lo_nxt;
            hi_r    <= hi_nxt;
            dwell_r <= dwell_nxt;
            dcnt    <= dcnt_nxt;
            reps_r  <= reps_nxt;
            rep_cnt <= rep_cnt_nxt;
            m_r     <= m_nxt;
            err_r   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lo_nxt      = lo_r;
        hi_nxt      = hi_r;
        dwell_nxt   = dwell_r;
        dcnt_nxt    = dcnt;
        reps_nxt    = reps_r;
        rep_cnt_nxt = rep_cnt;
        m_nxt       = m_r;
        err_nxt     = 1'b0;
        ctr_en      = 1'b0;
        ctr_load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (lo < hi) begin
                        lo_nxt      = lo;
                        hi_nxt      = hi;
                        dwell_nxt   = dwell;
                        reps_nxt    = reps;
                        rep_cnt_nxt = '0;
                        m_nxt       = 1'b1;
                        ctr_load    = 1'b1;
                        state_nxt   = UP;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            UP: begin
                if (q != hi_r) begin
                    ctr_en = 1'b1;
                end else if (dwell_r == '0) begin
                    m_nxt     = 1'b0;
                    state_nxt = DOWN;
                end else begin
                    dcnt_nxt  = dwell_r;
                    state_nxt = DWELL_HI;
                end
            end
            DWELL_HI: begin
                dcnt_nxt = dcnt - DWELL_W'(1);
                if (dcnt == DWELL_W'(1)) begin
                    m_nxt     = 1'b0;
                    state_nxt = DOWN;
                end
            end
            DOWN: begin
                if (q != lo_r) begin
                    ctr_en = 1'b1;
                end else begin
                    // saturate so reps=0 (free-running) never wraps the count
                    rep_cnt_nxt = (rep_cnt == '1) ? rep_cnt : rep_cnt + REPS_W'(1);
                    if (reps_r != '0 && rep_cnt == reps_r - REPS_W'(1)) begin
                        state_nxt = DONE;
                    end else if (dwell_r == '0) begin
                        m_nxt     = 1'b1;
                        state_nxt = UP;
                    end else begin
                        dcnt_nxt  = dwell_r;
                        state_nxt = DWELL_LO;
                    end
                end
            end
            DWELL_LO: begin
                dcnt_nxt = dcnt - DWELL_W'(1);
                if (dcnt == DWELL_W'(1)) begin
                    m_nxt     = 1'b1;
                    state_nxt = UP;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // abort freezes q and M and beats every other transition, including DONE entry
        if (abort && state != IDLE) begin
            state_nxt   = IDLE;
            lo_nxt      = lo_r;
            rep_cnt_nxt = rep_cnt;
            m_nxt       = m_r;
            err_nxt     = 1'b0;
            ctr_en      = 1'b0;
            ctr_load    = 1'b0;
        end
    end

    assign M    = m_r;
    assign done = (state == DONE);
    assign err  = (state == DONE) && err_r;
    assign busy = (state != IDLE) && !((state == DONE) && err_r);

endmodule

// File: tb/tb_up_down_sweep_ctrl.sv
// Directed bench for the sweep sequencer; inputs change and outputs are sampled on the falling edge.
module tb_up_down_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort;
    logic [3:0] lo, hi, dwell, reps;
    logic [3:0] q;
    logic       M, busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    up_down_sweep_ctrl #(.WIDTH(4), .DWELL_W(4), .REPS_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .lo    (lo),
        .hi    (hi),
        .dwell (dwell),
        .reps  (reps),
        .q     (q),
        .M     (M),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    int eq2[10] = '{2, 3, 4, 5, 5, 5, 4, 3, 2, 2};
    int exp3[$];
    int done_cnt, hi_cnt, hits;
    bit found;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        lo = 4'd0; hi = 4'd0; dwell = 4'd0; reps = 4'd0;

        // reset state
        @(negedge clk);
        chk("rst_q", q, 0);
        chk("rst_M", M, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        // test 1: async reset mid-sweep, while counting down
        lo = 4'd3; hi = 4'd5; dwell = 4'd0; reps = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t1_pre_q", q, 4);
        chk("t1_pre_M", M, 0);
        #2 reset = 1'b1;
        #1;
        chk("t1_q", q, 0);
        chk("t1_M", M, 1);
        chk("t1_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_q", q, 0);

        // test 2 + 6: basic sweep; start and limit changes mid-sweep must be ignored
        lo = 4'd2; hi = 4'd5; dwell = 4'd1; reps = 4'd1; start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            chk($sformatf("t2_q[%0d]", k), q, eq2[k]);
            chk($sformatf("t2_M[%0d]", k), M, (k < 5) ? 1 : 0);
            chk($sformatf("t2_done[%0d]", k), done, (k == 9) ? 1 : 0);
            chk($sformatf("t2_busy[%0d]", k), busy, 1);
            if (k == 2) begin start = 1'b1; lo = 4'd0; hi = 4'd9; dwell = 4'd0; end
            if (k == 4) start = 1'b0;
        end
        @(negedge clk);
        chk("t2_end_busy", busy, 0);
        chk("t2_end_done", done, 0);
        chk("t2_end_q", q, 2);

        // test 4: lo == hi is an error, q untouched, busy never rises
        lo = 4'd7; hi = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_err", err, 1);
        chk("t4_busy", busy, 0);
        chk("t4_q", q, 2);
        @(negedge clk);
        chk("t4_done2", done, 0);
        chk("t4_err2", err, 0);
        chk("t4_busy2", busy, 0);

        // test 3: full range, two reps, no dwell
        exp3.push_back(0);
        for (int r = 0; r < 2; r++) begin
            for (int v = 1; v <= 15; v++) exp3.push_back(v);
            exp3.push_back(15);
            for (int v = 14; v >= 0; v--) exp3.push_back(v);
            exp3.push_back(0);
        end
        lo = 4'd0; hi = 4'd15; dwell = 4'd0; reps = 4'd2; start = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < exp3.size(); k++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("t3_q[%0d]", k), q, exp3[k]);
            if (done) done_cnt++;
        end
        chk("t3_done_last", done, 1);
        @(negedge clk);
        if (done) done_cnt++;
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_end_busy", busy, 0);

        // test 5: reps=0 loops; abort on the second pass down at q=3
        lo = 4'd1; hi = 4'd4; dwell = 4'd2; reps = 4'd0; start = 1'b1;
        done_cnt = 0; hi_cnt = 0; hits = 0; found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_cnt++;
            if (q == 4'd4) hi_cnt++;
            if (q == 4'd3 && M == 1'b0 && busy) begin
                hits++;
                if (hits == 2) begin
                    found = 1'b1;
                    abort = 1'b1;
                end
            end
        end
        chk("t5_found", found, 1);
        chk("t5_hi_hold", hi_cnt, 8);
        chk("t5_no_done_run", done_cnt, 0);
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_q", q, 3);
        chk("t5_M", M, 0);
        chk("t5_done", done, 0);
        @(negedge clk);
        abort = 1'b0;
        chk("t5_idle_q", q, 3);
        chk("t5_idle_done", done, 0);
        chk("t5_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
